// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave). Signal names keep the CPU-side direction suffixes.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        ack_o;
    logic [31:0] data_o;
    logic        stall_o;

    // CPU side: issues requests, observes completion and stall
    modport master (
        output req_i, we_i, addr_i, data_i,
        input  ack_o, data_o, stall_o
    );

    // Memory side: consumes requests, produces completion and stall
    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output ack_o, data_o, stall_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder. Accepts one load/store at a time, completes
// it LATENCY cycles after the accept edge with a one-cycle ack, and holds the
// pipeline via stall_o while the request is outstanding.
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter only needs to hold LATENCY-1; keep at least one bit.
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_data_o;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_access;
    logic            w_ack;
    logic            w_accept;
    logic            w_from_inputs;
    logic            w_acc_we;
    logic [AW-1:0]   w_acc_idx;
    logic [31:0]     w_acc_data;
    logic [AW-1:0]   w_req_idx;
    logic            w_mem_we;
    logic            w_unused_addr;

    // Byte address to word index; low two bits and bits above the array wrap away.
    assign w_req_idx     = bus.addr_i[AW+1:2];
    assign w_unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};

    assign w_accept = (r_state == S_IDLE) && bus.req_i;

    // With LATENCY = 1 the access happens on the accept edge itself, so the
    // live request inputs are used; otherwise the latched copies are.
    assign w_from_inputs = (r_state == S_IDLE);
    assign w_acc_we      = w_from_inputs ? bus.we_i   : r_we;
    assign w_acc_idx     = w_from_inputs ? w_req_idx  : r_idx;
    assign w_acc_data    = w_from_inputs ? bus.data_i : r_wdata;

    // Reset gates the write so a request held high during reset never lands.
    assign w_mem_we = w_access && w_acc_we && !rst_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode, access strobe and completion pulse
    always_comb begin
        w_state_next = r_state;
        w_access     = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_i) begin
                    if (LATENCY == 1) begin
                        w_state_next = S_DONE;
                        w_access     = 1'b1;
                    end else begin
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_DONE;
                    w_access     = 1'b1;
                end
            end
            S_DONE: begin
                w_ack        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Latch the request on accept and count down the remaining latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_we    <= bus.we_i;
            r_idx   <= w_req_idx;
            r_wdata <= bus.data_i;
        end else if (r_state == S_BUSY) begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    // Storage array write port; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

    // Registered load result; held between loads and untouched by stores
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data_o <= '0;
        end else if (w_access && !w_acc_we) begin
            r_data_o <= r_mem[w_acc_idx];
        end
    end

    assign bus.ack_o   = w_ack;
    assign bus.data_o  = r_data_o;
    assign bus.stall_o = bus.req_i & ~w_ack;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with LATENCY=4 and one
// with LATENCY=1, each compared against a transaction-level memory model.
module tb_dmem_responder;
    localparam int DEPTH = 32;
    localparam int LAT0  = 4;
    localparam int LAT1  = 1;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (bus0.slave)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_m  [2][DEPTH];
    logic [31:0] dout_m [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        if (d == 0) begin
            bus0.req_i = req; bus0.we_i = we; bus0.addr_i = addr; bus0.data_i = data;
        end else begin
            bus1.req_i = req; bus1.we_i = we; bus1.addr_i = addr; bus1.data_i = data;
        end
    endtask

    task automatic sample(input int d, output logic ack, output logic [31:0] dout, output logic stall);
        if (d == 0) begin
            ack = bus0.ack_o; dout = bus0.data_o; stall = bus0.stall_o;
        end else begin
            ack = bus1.ack_o; dout = bus1.data_o; stall = bus1.stall_o;
        end
    endtask

    // One request from the cycle it is presented to the cycle after its ack.
    // mode 0: hold inputs; 1: scramble inputs after accept; 2: drop req after accept.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input int mode);
        int          lat;
        int          w;
        logic        req_now;
        logic        a;
        logic        st;
        logic [31:0] q;
        lat     = (d == 0) ? LAT0 : LAT1;
        w       = int'((addr >> 2) % 32'(DEPTH));
        req_now = 1'b1;
        $display("[TB] dut%0d %s addr=0x%08h word=%0d data=0x%08h mode=%0d",
                 d, we ? "ST" : "LD", addr, w, we ? data : mem_m[d][w], mode);
        drive(d, 1'b1, we, addr, data);
        for (int k = 0; k <= lat; k++) begin
            #1;
            sample(d, a, q, st);
            if (k == lat) begin
                if (we) mem_m[d][w] = data;
                else    dout_m[d]   = mem_m[d][w];
            end
            check_eq($sformatf("dut%0d ack c%0d", d, k),   32'(a),  32'(k == lat));
            check_eq($sformatf("dut%0d stall c%0d", d, k), 32'(st), 32'(req_now && (k != lat)));
            check_eq($sformatf("dut%0d data_o c%0d", d, k), q, dout_m[d]);
            @(negedge clk);
            if (k == 0 && mode == 1) drive(d, 1'b1, 1'($urandom), $urandom, $urandom);
            if (k == 0 && mode == 2) begin
                req_now = 1'b0;
                drive(d, 1'b0, we, addr, data);
            end
        end
    endtask

    task automatic idle(input int d, input int n);
        logic        a;
        logic        st;
        logic [31:0] q;
        drive(d, 1'b0, 1'($urandom), $urandom, $urandom);
        repeat (n) begin
            #1;
            sample(d, a, q, st);
            check_eq($sformatf("dut%0d idle ack", d),    32'(a),  32'd0);
            check_eq($sformatf("dut%0d idle stall", d),  32'(st), 32'd0);
            check_eq($sformatf("dut%0d idle data_o", d), q, dout_m[d]);
            @(negedge clk);
        end
    endtask

    task automatic random_phase(input int d, input int n);
        for (int i = 0; i < DEPTH; i++) begin
            txn(d, 1'b1, 32'(i * 4 + $urandom_range(0, 3) + $urandom_range(0, 7) * DEPTH * 4),
                $urandom, 0);
        end
        for (int i = 0; i < n; i++) begin
            txn(d, 1'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 3)));
        end
        idle(d, 1);
    endtask

    initial begin
        logic        a;
        logic        st;
        logic [31:0] q;
        dout_m[0] = '0;
        dout_m[1] = '0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Reset state while reset is held
        #1;
        sample(0, a, q, st);
        check_eq("reset ack", 32'(a), 32'd0);
        check_eq("reset data_o", q, 32'd0);
        check_eq("reset stall", 32'(st), 32'd0);
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        idle(0, 2);
        idle(1, 2);

        // Store timing, then back-to-back load-back
        txn(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0);
        txn(0, 1'b0, 32'h0000_0008, 32'h0, 0);
        idle(0, 2);

        // Asynchronous reset mid-cycle with a load outstanding
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        @(posedge clk);
        #2;
        rst0 = 1'b1;
        #1;
        sample(0, a, q, st);
        check_eq("async rst ack", 32'(a), 32'd0);
        check_eq("async rst data_o", q, 32'd0);
        check_eq("async rst stall follows req", 32'(st), 32'd1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        sample(0, a, q, st);
        check_eq("async rst stall low", 32'(st), 32'd0);
        dout_m[0] = '0;
        @(negedge clk);
        rst0 = 1'b0;
        idle(0, 5);

        // Address wrap, misalignment and latching of request inputs
        txn(0, 1'b1, 32'h0000_0084, 32'h0000_1234, 1);
        txn(0, 1'b0, 32'h0000_0007, 32'h0, 0);

        // Reset in the middle of a store leaves the old word intact
        txn(0, 1'b1, 32'h0000_0008, 32'h0000_0011, 0);
        idle(0, 1);
        $display("[TB] dut0 ST addr=0x00000008 word=2 data=0x00000055 aborted by reset");
        drive(0, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0055);
        repeat (2) @(negedge clk);
        rst0 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        dout_m[0] = '0;
        repeat (3) begin
            #1;
            sample(0, a, q, st);
            check_eq("mid-store rst ack", 32'(a), 32'd0);
            check_eq("mid-store rst data_o", q, 32'd0);
            @(negedge clk);
        end
        rst0 = 1'b0;
        idle(0, 6);
        txn(0, 1'b0, 32'h0000_0008, 32'h0, 0);

        // Early req drop still completes
        txn(0, 1'b0, 32'h0000_0084, 32'h0, 2);
        idle(0, 1);

        random_phase(0, 40);

        // LATENCY = 1: back-to-back with continuous req
        txn(1, 1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 0);
        txn(1, 1'b0, 32'h0000_000C, 32'h0, 0);
        txn(1, 1'b0, 32'h0000_008C, 32'h0, 1);
        idle(1, 2);
        random_phase(1, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
